delay_reader: RTL and testbench
===============================

# delay_reader

Read-side partner of the capture write-address counter in the signal-generator datapath. The counter writes audio samples into a circular dual-port RAM. This block follows the writer and issues one RAM read per written sample at a programmable delay behind it, then presents the returned samples on a valid/ready stream. Consumers are the DAC/plot output stage.

## Interface
- `A_WIDTH`, default 9: RAM address width; equals the write counter width.
- `D_WIDTH`, default 8: sample width.

- `clk` input, 1 bit: clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `wr_en` input, 1 bit: the writer stores a sample at `wr_addr` this cycle.
- `wr_addr` input, `A_WIDTH` bits: the writer's current address (counter output).
- `delay` input, `A_WIDTH` bits: read offset in samples. Sampled only in IDLE or on `restart`.
- `restart` input, 1 bit: synchronous re-arm. Flushes the block and re-latches `delay`.
- `rd_en` output, 1 bit: RAM read strobe.
- `rd_addr` output, `A_WIDTH` bits: RAM read address.
- `rd_data` input, `D_WIDTH` bits: RAM read data, valid 1 cycle after `rd_en`.
- `out_valid` output, 1 bit: `out_data` holds a sample.
- `out_ready` input, 1 bit: consumer accepts the sample.
- `out_data` output, `D_WIDTH` bits: delayed sample.
- `overrun` output, 1 bit: sticky flag; a sample was dropped. Cleared only by reset.

## Operation
- **States:** IDLE, FILL, RUN.
  - Reset puts the block in IDLE.
  - IDLE lasts 1 cycle. It latches `delay` into `delay_q`, clears `fill_cnt`, then moves to FILL. `wr_en` is ignored in IDLE.
  - FILL: each `wr_en` increments `fill_cnt`; no reads are issued. When `fill_cnt == delay_q` at the start of a cycle, the state becomes RUN. With `delay_q == 0`, RUN is entered on the cycle after IDLE.
  - RUN: each `wr_en` creates a read request for `wr_addr - delay_q`, taken modulo 2^`A_WIDTH`, so the address wraps naturally.
- **Request issue:** the request is registered. `rd_en`/`rd_addr` are asserted the cycle after `wr_en`, which guarantees the RAM write has completed before it is read (no read-during-write).
- **Return:** `rd_data` is captured the cycle after `rd_en` and pushed into a 2-entry output FIFO.
- **Credit rule:** a request is issued only if FIFO occupancy plus in-flight reads is less than 2, with the occupancy term already accounting for a pop in the same cycle. Otherwise:
  - the request is dropped,
  - no `rd_en` is asserted,
  - `overrun` is set to 1.
- The writer is never stalled.
- **Output handshake:**
  - A transfer occurs when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, `out_data` stays stable and samples leave in write order.
  - `out_valid` never drops without a transfer, except on `restart` or reset.
- **`restart`** (any state, highest priority):
  - latches `delay` and clears `fill_cnt`;
  - flushes the FIFO and discards any in-flight read;
  - enters FILL next cycle;
  - ignores a `wr_en` in the same cycle;
  - leaves `overrun` unchanged.

## Timing
- Reset values: `rd_en` = 0, `rd_addr` = 0, `out_valid` = 0, `out_data` = 0, `overrun` = 0. State is IDLE, and `delay_q` and `fill_cnt` are 0.
- Reset acts asynchronously on assertion; outputs reach reset values without a clock edge.
- Latency, in RUN with the FIFO empty: `wr_en` at cycle T gives `rd_en` at T+1, `rd_data` at T+2, and `out_valid` with the sample at T+3.
- Throughput is 1 sample per cycle when `out_ready` is held at 1.
- `fill_cnt` is `A_WIDTH` bits wide and saturates at `delay_q`.
- Simultaneous FIFO push and pop at occupancy 2 is impossible by the credit rule. At occupancy 1, push and pop in the same cycle keeps occupancy at 1.

## Structure
- Package `delay_reader_pkg`:
  - `state_t` enum {IDLE, FILL, RUN};
  - `localparam FIFO_DEPTH = 2`.
- Sub-module `sample_fifo2`: a 2-entry registered FIFO with push, pop, full, empty and count. Same clock and reset scheme.
- Top level: FSM, request register, in-flight flag, credit logic and overrun flag.

## Test plan
- **Zero delay:** after reset, `delay` = 0, RAM[5] = 0x7F. `wr_en` with `wr_addr` = 5 at T gives `rd_en`=1 and `rd_addr`=5 at T+1, then `out_valid`=1 with `out_data`=0x7F at T+3.
- **Fill:** `delay` = 4, writes to addresses 0..7 with RAM[i] = i+0x10. Writes 0–3 produce no `rd_en`. The write to address 4 reads address 0. Outputs are 0x10, 0x11, 0x12, 0x13 in order.
- **Wrap:** `delay` = 3, in RUN, write at `wr_addr` = 1 gives `rd_addr` = 510 (`A_WIDTH` = 9).
- **Backpressure:** `out_ready` = 0 and a write every cycle in RUN. Exactly 2 samples are held, the third request issues no `rd_en`, and `overrun` goes to 1 and stays 1. `out_data` is stable until `out_ready` = 1.
- **Restart:** mid-RUN with 1 sample in the FIFO and 1 read in flight, `restart` with `delay` = 2. `out_valid` = 0 next cycle, the in-flight data is discarded, and the next 2 writes produce no reads.
- **Asynchronous reset:** assert `rst` (low) mid-RUN between clock edges. All outputs read back their reset values immediately, and after release the block starts again in IDLE.

Source files
------------

// File: rtl/delay_reader_pkg.sv
// delay_reader_pkg: shared types and sizing for the delayed RAM reader
package delay_reader_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/delay_reader_sample_fifo2.sv
// sample_fifo2: two-entry registered FIFO holding returned samples for the output stream
module sample_fifo2
    import delay_reader_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [D_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output logic [D_WIDTH-1:0] o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [CNT_W-1:0]   o_count
);
    logic [D_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic               r_wptr;
    logic               r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = r_count == CNT_W'(FIFO_DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) r_mem[r_wptr] <= i_data;
            r_wptr  <= r_wptr ^ w_push;
            r_rptr  <= r_rptr ^ w_pop;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/delay_reader.sv
// delay_reader: follows the capture writer and streams samples read a programmable distance behind it
module delay_reader
    import delay_reader_pkg::*;
#(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [A_WIDTH-1:0] delay,
    input  logic               restart,
    output logic               rd_en,
    output logic [A_WIDTH-1:0] rd_addr,
    input  logic [D_WIDTH-1:0] rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               overrun
);
    state_t             r_state;
    state_t             w_next;
    logic [A_WIDTH-1:0] r_delay_q;
    logic [A_WIDTH-1:0] r_fill_cnt;
    logic [A_WIDTH-1:0] r_rd_addr;
    logic [A_WIDTH-1:0] w_delay_next;
    logic [A_WIDTH-1:0] w_fill_next;
    logic               r_req;
    logic               r_inflight;
    logic               r_overrun;
    logic               w_run;
    logic               w_accept;
    logic               w_pop;
    logic               w_credit;
    logic               w_issue;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_load;

    // FILL with the counter already at the delay behaves as RUN, so the first
    // post-fill write is read back without losing a cycle to the state change
    assign w_run     = (r_state == RUN) || (r_state == FILL && r_fill_cnt == r_delay_q);
    assign w_accept  = wr_en && w_run && !restart;
    assign w_pop     = !w_empty && out_ready;
    // samples already owed to the consumer: queued (after this cycle's pop) plus the read returning now
    assign w_load    = w_count - CNT_W'(w_pop) + CNT_W'(r_inflight);
    assign w_credit  = w_load < CNT_W'(FIFO_DEPTH);
    assign w_issue   = r_req && w_credit && !restart;
    assign w_drop    = r_req && !w_credit && !restart;
    assign rd_en     = w_issue;
    assign rd_addr   = r_rd_addr;
    assign out_valid = !w_empty;
    assign overrun   = r_overrun;

    // next state, fill counter (saturating at the delay) and delay latch
    always_comb begin
        w_next       = r_state;
        w_fill_next  = r_fill_cnt;
        w_delay_next = r_delay_q;
        if (restart || r_state == IDLE) begin
            w_next       = FILL;
            w_fill_next  = '0;
            w_delay_next = delay;
        end else if (r_state == FILL) begin
            w_next      = w_run ? RUN : FILL;
            w_fill_next = r_fill_cnt + A_WIDTH'(wr_en && !w_run);
        end
    end

    // FSM state, request register, in-flight flag and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_delay_q  <= '0;
            r_fill_cnt <= '0;
            r_req      <= 1'b0;
            r_rd_addr  <= '0;
            r_inflight <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_delay_q  <= w_delay_next;
            r_fill_cnt <= w_fill_next;
            r_req      <= w_accept;
            if (w_accept) r_rd_addr <= wr_addr - r_delay_q;
            r_inflight <= w_issue;
            r_overrun  <= r_overrun || w_drop;
        end
    end

    // every issued read has a reserved FIFO slot, so a returning sample never meets a full FIFO
    assert property (@(posedge clk) disable iff (!rst) !(r_inflight && w_full));

    sample_fifo2 #(.D_WIDTH(D_WIDTH)) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_flush (restart),
        .i_push  (r_inflight),
        .i_data  (rd_data),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_delay_reader.sv
// tb_delay_reader: random and directed stimulus against a sample-accounting reference model
module tb_delay_reader;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          restart = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] delay = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          overrun;
    logic [DW-1:0] ram [1<<AW];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } item_t;

    // reference model: requests owed, samples awaiting the consumer, write count since arming
    item_t         q[$];
    int            cyc, issued, popped, m_writes;
    bit            m_idle, m_pend, m_ovr;
    logic [AW-1:0] m_addr, m_delay;

    logic          o_rd_en, o_valid, o_ovr;
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] o_data;
    logic [DW-1:0] got_q[$];

    always #5 clk = ~clk;

    delay_reader #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .delay     (delay),
        .restart   (restart),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overrun   (overrun)
    );

    // dual-port RAM with a one-cycle registered read
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        issued = 0;
        popped = 0;
        m_idle = 1;
        m_pend = 0;
        m_ovr = 0;
        m_writes = 0;
        m_delay = '0;
    endtask

    // one clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic rs, input logic [AW-1:0] dl, input logic rdy);
        bit ev, er;
        int pop;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; restart = rs; delay = dl; out_ready = rdy;
        #1;
        o_rd_en = rd_en; o_rd_addr = rd_addr; o_valid = out_valid; o_data = out_data; o_ovr = overrun;
        ev = q.size() > 0 && q[0].rdy <= cyc;
        pop = (ev && rdy) ? 1 : 0;
        er = m_pend && !rs && (issued - popped - pop < 2);
        check("rd_en", rd_en, er);
        if (er) check("rd_addr", rd_addr, m_addr);
        check("out_valid", out_valid, ev);
        if (ev) check("out_data", out_data, q[0].data);
        check("overrun", overrun, m_ovr);
        if (out_valid && rdy) got_q.push_back(out_data);
        if (m_pend && !rs && !er) m_ovr = 1;
        if (pop != 0) begin
            void'(q.pop_front());
            popped++;
        end
        if (er) begin
            q.push_back('{data: ram[m_addr], rdy: cyc + 2});
            issued++;
        end
        m_pend = 0;
        if (rs) begin
            q.delete();
            issued = 0;
            popped = 0;
            m_delay = dl;
            m_writes = 0;
            m_idle = 0;
        end else if (m_idle) begin
            m_delay = dl;
            m_writes = 0;
            m_idle = 0;
        end else if (we && m_writes >= int'(m_delay)) begin
            m_pend = 1;
            m_addr = wa - m_delay;
        end else if (we) begin
            m_writes++;
        end
        cyc++;
    endtask

    // assert reset between edges, check outputs before any clock, release just after a rising edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        wr_en = 1'b0; restart = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int n, bad;
        bit seen;
        logic [DW-1:0] held;
        logic [AW-1:0] wp, rdl;
        logic [AW-1:0] wrap_addrs [4];
        wrap_addrs[0] = 9'd510; wrap_addrs[1] = 9'd511; wrap_addrs[2] = 9'd0; wrap_addrs[3] = 9'd1;
        cyc = 0;
        do_reset();

        // zero delay: write at T, read at T+1, sample at T+3
        step(0, 0, 0, 0, 0, 0);
        step(1, 5, 8'h7F, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("zd_rd_en", o_rd_en, 1);
        check("zd_rd_addr", o_rd_addr, 5);
        step(0, 0, 0, 0, 0, 0);
        check("zd_valid_early", o_valid, 0);
        step(0, 0, 0, 0, 0, 1);
        check("zd_valid", o_valid, 1);
        check("zd_data", o_data, 8'h7F);

        // fill with delay 4
        step(0, 0, 0, 1, 4, 1);
        got_q.delete();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, AW'(i), DW'(i + 16), 0, 4, 1);
            if (i >= 1 && i <= 4) n += int'(o_rd_en);
            if (i == 5) begin
                check("fill_first_rd", o_rd_en, 1);
                check("fill_first_addr", o_rd_addr, 0);
            end
        end
        check("fill_no_reads", n, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4, 1);
        check("fill_out_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) if (got_q.size() > i) check("fill_out", got_q[i], 32'(16 + i));
        check("fill_no_overrun", o_ovr, 0);

        // wrap: delay 3, write at address 1 reads 510
        step(0, 0, 0, 1, 3, 1);
        for (int i = 0; i < 4; i++) step(1, wrap_addrs[i], DW'($urandom), 0, 3, 1);
        step(0, 0, 0, 0, 3, 1);
        check("wrap_rd_en", o_rd_en, 1);
        check("wrap_rd_addr", o_rd_addr, 510);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3, 1);

        // backpressure: two samples held, the rest dropped, overrun sticks
        n = 0; bad = 0; seen = 0; held = '0;
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            step(i < 8, AW'(i + 2), DW'($urandom), 0, 3, 0);
            n += int'(o_rd_en);
            if (o_valid && !seen) begin
                seen = 1;
                held = o_data;
            end else if (o_valid && o_data !== held) bad++;
        end
        check("bp_reads", n, 2);
        check("bp_stable", bad, 0);
        check("bp_overrun", o_ovr, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3, 1);
        check("bp_held", got_q.size(), 2);
        check("bp_overrun_sticky", o_ovr, 1);

        // restart with one sample queued and one read in flight
        step(1, 10, 8'h55, 0, 3, 0);
        step(1, 11, 8'h56, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 1, 2, 0);
        check("rs_pre_valid", o_valid, 1);
        got_q.delete();
        step(1, 20, 8'hA0, 0, 2, 0);
        check("rs_flushed", o_valid, 0);
        step(1, 21, 8'hA1, 0, 2, 0);
        check("rs_fill_rd0", o_rd_en, 0);
        step(1, 22, 8'hA2, 0, 2, 0);
        check("rs_fill_rd1", o_rd_en, 0);
        step(0, 0, 0, 0, 2, 1);
        check("rs_rd_en", o_rd_en, 1);
        check("rs_rd_addr", o_rd_addr, 20);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2, 1);
        check("rs_out_count", got_q.size(), 1);
        if (got_q.size() > 0) check("rs_out_data", got_q[0], 8'hA0);

        // random traffic with occasional restarts and one asynchronous reset mid-run
        wp = '0;
        rdl = 9'd2;
        for (int i = 0; i < 3000; i++) begin
            logic we, rs;
            if (i == 1500) begin
                do_reset();
                rdl = AW'($urandom_range(0, 7));
            end
            we = ($urandom % 4) != 0;
            rs = ($urandom % 97) == 0;
            if (rs) rdl = AW'($urandom_range(0, 7));
            step(we, wp, DW'($urandom), rs, rdl, ($urandom % 3) != 0);
            if (we) wp = wp + 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
